dotp_seq: RTL and testbench

- Operand sequencer and accumulator wrapped around the team's 2-cycle ROM multiplier.
- Accepts a stream of DATA_WIDTH-bit operand pairs over a valid/ready handshake and drives them into the multiplier.
- Tracks the multiplier's fixed latency with a tag pipeline and accumulates the returned products.
- Presents one dot-product result per job over a valid/ready output handshake.

---
 rtl/dotp_seq_if.sv | 26 ++
 rtl/dotp_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_dotp_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dotp_seq_if.sv
// dotp_seq_if: operand-stream and result-stream handshake bundle for dotp_seq.
//   in_valid/in_ready/in_a/in_b    : operand pair stream (producer -> sequencer)
//   out_valid/out_ready/result     : dot-product result stream (sequencer -> consumer)
// Modports: master = producer/consumer side, slave = the sequencer.
interface dotp_seq_if #(
    parameter int DATA_WIDTH = 7,
    parameter int ACC_WIDTH  = 22
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  result;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/dotp_seq.sv
// dotp_seq: operand sequencer and accumulator around a fixed-latency multiplier.
// Streams operand pairs into the multiplier, follows each pair through the
// multiplier latency with a tag pipe and sums the returned products; one
// result per job is offered on the output handshake.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start_i, len_i  : job start (sampled in IDLE only) and pair count
//   io (slave)      : in_valid/in_ready/in_a/in_b, out_valid/out_ready/result
//   mul_da_o/db_o   : registered operands to the multiplier
//   mul_q_i         : product from the multiplier
//   busy_o          : high in every state except IDLE
// Build option: define DOTP_SAT_EN to make the accumulator saturate at
// 2**ACC_WIDTH-1 (sticky until the next start) instead of wrapping.
module dotp_seq #(
    parameter int DATA_WIDTH  = 7,
    parameter int LEN_WIDTH   = 8,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH + LEN_WIDTH,
    parameter int MUL_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    dotp_seq_if.slave               io,
    output logic [DATA_WIDTH-1:0]   mul_da_o,
    output logic [DATA_WIDTH-1:0]   mul_db_o,
    input  logic [2*DATA_WIDTH-1:0] mul_q_i,
    output logic                    busy_o
);
    // A tag enters with the operands and leaves the edge after mul_q holds the product.
    localparam int TAG_DEPTH = MUL_LATENCY + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    issued_q, issued_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [TAG_DEPTH-1:0]    tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   mul_da_q, mul_da_d;
    logic [DATA_WIDTH-1:0]   mul_db_q, mul_db_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [ACC_WIDTH-1:0]    result_q, result_d;
    logic                    accept_s;
    logic                    start_ok_s;
    logic [LEN_WIDTH-1:0]    issued_inc_s;

`ifdef DOTP_SAT_EN
    logic                    sat_q, sat_d;
    logic [ACC_WIDTH:0]      sum_s;

    // Sum with carry out so overflow can be detected.
    function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [2*DATA_WIDTH-1:0] p);
        acc_add = {1'b0, a} + (ACC_WIDTH+1)'(p);
    endfunction
`else
    // Plain modulo sum of the accumulator and a zero-extended product.
    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [2*DATA_WIDTH-1:0] p);
        acc_add = a + ACC_WIDTH'(p);
    endfunction
`endif

    // in_ready is registered and only high in RUN, so a handshake implies RUN.
    assign accept_s     = io.in_valid & in_ready_q;
    assign start_ok_s   = (state_q == S_IDLE) && start_i;
    assign issued_inc_s = issued_q + LEN_WIDTH'(1);

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign mul_da_o     = mul_da_q;
    assign mul_db_o     = mul_db_q;
    assign busy_o       = busy_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == LEN_WIDTH'(0)) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && (issued_inc_s == len_q)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Empty pipe means the last product has already been added.
                if (tag_q == TAG_DEPTH'(0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (out_valid_q && io.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: job setup, operand issue, tag pipe and accumulation.
    always_comb begin
        len_d    = len_q;
        issued_d = issued_q;
        acc_d    = acc_q;
        mul_da_d = mul_da_q;
        mul_db_d = mul_db_q;
        tag_d    = {tag_q[TAG_DEPTH-2:0], accept_s};
`ifdef DOTP_SAT_EN
        sat_d    = sat_q;
        sum_s    = acc_add(acc_q, mul_q_i);
`endif
        if (start_ok_s) begin
            len_d    = len_i;
            issued_d = LEN_WIDTH'(0);
            acc_d    = ACC_WIDTH'(0);
`ifdef DOTP_SAT_EN
            sat_d    = 1'b0;
`endif
        end else if (tag_q[TAG_DEPTH-1]) begin
`ifdef DOTP_SAT_EN
            if (sat_q || sum_s[ACC_WIDTH]) begin
                acc_d = {ACC_WIDTH{1'b1}};
                sat_d = 1'b1;
            end else begin
                acc_d = sum_s[ACC_WIDTH-1:0];
                sat_d = sat_q;
            end
`else
            acc_d = acc_add(acc_q, mul_q_i);
`endif
        end else begin
            acc_d = acc_q;
        end

        if (accept_s) begin
            mul_da_d = io.in_a;
            mul_db_d = io.in_b;
            issued_d = issued_inc_s;
        end else begin
            mul_da_d = mul_da_q;
            mul_db_d = mul_db_q;
        end
    end

    // Registered-output next values, derived from the upcoming state.
    always_comb begin
        in_ready_d  = (state_d == S_RUN);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        // Capture the sum only on entry to DONE so it stays stable while stalled.
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            result_d = acc_d;
        end else begin
            result_d = result_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= LEN_WIDTH'(0);
            issued_q    <= LEN_WIDTH'(0);
            acc_q       <= ACC_WIDTH'(0);
            tag_q       <= TAG_DEPTH'(0);
            mul_da_q    <= DATA_WIDTH'(0);
            mul_db_q    <= DATA_WIDTH'(0);
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= ACC_WIDTH'(0);
`ifdef DOTP_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            len_q       <= len_d;
            issued_q    <= issued_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            mul_da_q    <= mul_da_d;
            mul_db_q    <= mul_db_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
`ifdef DOTP_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_dotp_seq.sv
// tb_dotp_seq: self-checking bench for dotp_seq. Two instances run in lockstep
// from the same stimulus: the default width and a narrow ACC_WIDTH=16 copy
// used for the overflow case. A two-stage multiplier model feeds mul_q.
module tb_dotp_seq;
    localparam int DW  = 7;
    localparam int LW  = 8;
    localparam int AW  = 2*DW + LW;
    localparam int AW2 = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic [DW-1:0]   da, db, da2, db2;
    logic [2*DW-1:0] p1, mq, p1b, mq2;
    logic            busy, busy2;
    int              cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int qa[$];
    int qb[$];
    int vpat[$];
    int gap_pct = 0;
    int last_acc = 0;

    dotp_seq_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW))  bus  ();
    dotp_seq_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW2)) bus2 ();

    dotp_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW), .MUL_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len), .io(bus),
        .mul_da_o(da), .mul_db_o(db), .mul_q_i(mq), .busy_o(busy)
    );

    dotp_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW2), .MUL_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len), .io(bus2),
        .mul_da_o(da2), .mul_db_o(db2), .mul_q_i(mq2), .busy_o(busy2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_a      = bus.in_a;
    assign bus2.in_b      = bus.in_b;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier models: product valid two edges after the operands change.
    always @(posedge clk) begin
        p1  <= da * db;
        mq  <= p1;
        p1b <= da2 * db2;
        mq2 <= p1b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference dot product computed from the pair lists.
    function automatic longint model(input int aw);
        longint s = 0;
        longint top = (longint'(1) << aw);
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
`ifdef DOTP_SAT_EN
        return (s > top - 1) ? top - 1 : s;
`else
        return s % top;
`endif
    endfunction

    task automatic set_pairs(input int n, input int a, input int b);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(a < 0 ? int'($urandom_range(127)) : a);
            qb.push_back(b < 0 ? int'($urandom_range(127)) : b);
        end
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LW'(n);
        step();
        start = 1'b0;
        len   = LW'($urandom);
    endtask

    task automatic feed(input int n_acc, input string tag);
        int  idx = 0;
        int  steps = 0;
        int  pi = 0;
        bit  v;
        bit  acc;
        while (idx < n_acc && steps < 2000) begin
            if (pi < vpat.size()) begin
                v = (vpat[pi] != 0);
                pi++;
            end else begin
                v = ($urandom_range(99) >= gap_pct);
            end
            bus.in_valid = v;
            bus.in_a = v ? DW'(qa[idx]) : DW'($urandom);
            bus.in_b = v ? DW'(qb[idx]) : DW'($urandom);
            acc = v && bus.in_ready;
            step();
            steps++;
            if (acc) begin
                chk({tag, "_mul_da"}, 64'(da), 64'(qa[idx]));
                chk({tag, "_mul_db"}, 64'(db), 64'(qb[idx]));
                last_acc = cyc;
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        chk({tag, "_accepts"}, 64'(idx), 64'(n_acc));
    endtask

    task automatic wait_result(input string tag, input longint exp, input int exp_lat);
        int n = 0;
        while (!bus.out_valid && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1));
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(cyc - last_acc), 64'(exp_lat));
        chk({tag, "_result"}, 64'(bus.result), 64'(exp));
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        step();
        chk({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_busy_drop"}, 64'(busy), 64'(0));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_result"},    64'(bus.result),    64'(0));
        chk({tag, "_mul_da"},    64'(da),            64'(0));
        chk({tag, "_mul_db"},    64'(db),            64'(0));
        chk({tag, "_busy"},      64'(busy),          64'(0));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        reset_vals("reset");
        #10 rst_n = 1'b1;
        step();

        // Basic job, back-to-back
        qa = '{3, 5, 127};
        qb = '{4, 6, 127};
        start_job(3);
        chk("basic_in_ready", 64'(bus.in_ready), 64'(1));
        chk("basic_busy", 64'(busy), 64'(1));
        feed(3, "basic");
        chk("basic_in_ready_drop", 64'(bus.in_ready), 64'(0));
        wait_result("basic", model(AW), 4);
        take("basic");

        // Zero length
        qa.delete();
        qb.delete();
        start_job(0);
        chk("zero_out_valid", 64'(bus.out_valid), 64'(1));
        chk("zero_result", 64'(bus.result), 64'(0));
        chk("zero_in_ready", 64'(bus.in_ready), 64'(0));
        take("zero");

        // Input gaps and output stall
        qa = '{1, 2, 3, 4};
        qb = '{1, 2, 3, 4};
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        bus.out_ready = 1'b0;
        start_job(4);
        feed(4, "gap");
        vpat.delete();
        wait_result("gap", 30, 4);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3 || i == 6);
            len   = LW'(7);
            step();
            chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_result", 64'(bus.result), 64'(30));
        end
        start = 1'b0;
        take("gap");
        step();
        chk("gap_idle_busy", 64'(busy), 64'(0));
        chk("gap_idle_in_ready", 64'(bus.in_ready), 64'(0));

        // Maximum length, maximum operands
        set_pairs(255, 127, 127);
        start_job(255);
        feed(255, "max");
        wait_result("max", model(AW), 4);
        chk("max_const", 64'(bus.result), 64'(4112895));
        take("max");

        // Random jobs with random gaps
        gap_pct = 30;
        for (int j = 0; j < 3; j++) begin
            int n = int'($urandom_range(20, 1));
            set_pairs(n, -1, -1);
            start_job(n);
            feed(n, "rand");
            wait_result("rand", model(AW), 4);
            take("rand");
        end
        gap_pct = 0;

        // Reset mid-job
        set_pairs(5, -1, -1);
        start_job(5);
        feed(2, "midrst");
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        qa = '{2};
        qb = '{3};
        start_job(1);
        feed(1, "after_rst");
        wait_result("after_rst", 6, 4);
        take("after_rst");

        // Overflow on the narrow accumulator
        set_pairs(5, 127, 127);
        start_job(5);
        feed(5, "sat");
        wait_result("sat", model(AW), 4);
        chk("sat_narrow_valid", 64'(bus2.out_valid), 64'(1));
        chk("sat_narrow_result", 64'(bus2.result), 64'(model(AW2)));
`ifdef DOTP_SAT_EN
        chk("sat_narrow_const", 64'(bus2.result), 64'(65535));
`else
        chk("sat_narrow_const", 64'(bus2.result), 64'(15109));
`endif
        take("sat");
        chk("sat_narrow_busy", 64'(busy2), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
